bram_arb: RTL and testbench

//  Two-client arbiter/sequencer wrapping one 4kb iCE40 block RAM instance (module bram).

---
 rtl/bram_arb_pkg.sv | 23 ++
 rtl/bram_arb_bram.sv | 37 +++
 rtl/bram_arb.sv | 165 ++++++++++++++++
 tb/tb_bram_arb.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared client ids, op encodings and tie-break helper for bram_arb
package bram_arb_pkg;

  localparam logic CLI_0 = 1'b0;
  localparam logic CLI_1 = 1'b1;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // Winner among eligible clients; pref decides only when both are eligible.
  function automatic logic pick_client(input logic elig_0, input logic elig_1, input logic pref);
    logic win;
    if (elig_0 && elig_1) begin
      win = pref;
    end else if (elig_0) begin
      win = CLI_0;
    end else begin
      win = CLI_1;
    end
    return win;
  endfunction

endpackage

// File: rtl/bram_arb_bram.sv
// rtl/bram_arb_bram.sv - 4kb block RAM model: writes on rising edge, reads on falling edge
module bram #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 8
) (
  input  logic               i_clk,
  input  logic               i_wr_en,
  input  logic [ADDR_SZ-1:0] i_waddr,
  input  logic [DATA_SZ-1:0] i_wdata,
  input  logic               i_rd_en,
  input  logic [ADDR_SZ-1:0] i_raddr,
  output logic [DATA_SZ-1:0] o_rdata
);

  logic [DATA_SZ-1:0] mem_q [0:(1<<ADDR_SZ)-1];
  logic [DATA_SZ-1:0] rdata_q;

  // Write port commits on the rising edge following the issue edge.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  // Read port samples mid-cycle so a write committed at the same rising edge is visible;
  // with no read enabled the output is driven to zero.
  always_ff @(negedge i_clk) begin
    if (i_rd_en) begin
      rdata_q <= mem_q[i_raddr];
    end else begin
      rdata_q <= '0;
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/bram_arb.sv
// rtl/bram_arb.sv - two-client req/ack arbiter and sequencer around one block RAM
// Build option: BRAM_ARB_FIXED_PRI_EN (client 0 always wins ties, no round-robin pointer)
module bram_arb
  import bram_arb_pkg::*;
#(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_0,
  input  logic               i_wr_0,
  input  logic [ADDR_SZ-1:0] i_addr_0,
  input  logic [DATA_SZ-1:0] i_wdata_0,
  output logic               o_ack_0,
  output logic [DATA_SZ-1:0] o_rdata_0,
  input  logic               i_req_1,
  input  logic               i_wr_1,
  input  logic [ADDR_SZ-1:0] i_addr_1,
  input  logic [DATA_SZ-1:0] i_wdata_1,
  output logic               o_ack_1,
  output logic [DATA_SZ-1:0] o_rdata_1
);

  // Issue stage: one access presented to the RAM in the cycle after its grant.
  logic               issue_vld_q, issue_vld_d;
  logic               owner_q, owner_d;
  logic               op_q, op_d;
  logic               rd_en_q, rd_en_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_SZ-1:0] addr_q, addr_d;
  logic [DATA_SZ-1:0] wdata_q, wdata_d;

  // Completion stage: per-client ack pulse and held read data.
  logic               ack_0_q, ack_0_d;
  logic               ack_1_q, ack_1_d;
  logic [DATA_SZ-1:0] rdata_0_q, rdata_0_d;
  logic [DATA_SZ-1:0] rdata_1_q, rdata_1_d;

  logic [DATA_SZ-1:0] bram_rdata;

  logic inflight_0, inflight_1;
  logic elig_0, elig_1;
  logic gnt_vld, gnt_id, pref;
  logic op_sel;
  logic done_0, done_1;

`ifdef BRAM_ARB_FIXED_PRI_EN

  assign pref = CLI_0;

`else

  logic last_q, last_d;

  // Tie goes to the client not granted last; pointer moves only when a grant is made.
  always_comb begin
    pref   = (last_q == CLI_0) ? CLI_1 : CLI_0;
    last_d = gnt_vld ? gnt_id : last_q;
  end

  // Round-robin pointer; reset value makes client 0 the first preferred client.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_q <= CLI_1;
    end else begin
      last_q <= last_d;
    end
  end

`endif

  // A client stays ineligible while its op is in the issue stage and during its ack cycle,
  // which limits each client to one grant every three cycles.
  always_comb begin
    inflight_0 = issue_vld_q && (owner_q == CLI_0);
    inflight_1 = issue_vld_q && (owner_q == CLI_1);
    elig_0     = i_req_0 && !inflight_0 && !ack_0_q;
    elig_1     = i_req_1 && !inflight_1 && !ack_1_q;
    gnt_vld    = elig_0 || elig_1;
    gnt_id     = pick_client(elig_0, elig_1, pref);
  end

  // Next issue-stage contents: mux the winner's fields; RAM enables only for an actual grant.
  always_comb begin
    op_sel      = (gnt_id == CLI_0) ? i_wr_0 : i_wr_1;
    issue_vld_d = gnt_vld;
    rd_en_d     = gnt_vld && (op_sel == OP_RD);
    wr_en_d     = gnt_vld && (op_sel == OP_WR);
    owner_d     = owner_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if (gnt_vld) begin
      owner_d = gnt_id;
      op_d    = op_sel;
      addr_d  = (gnt_id == CLI_0) ? i_addr_0 : i_addr_1;
      wdata_d = (gnt_id == CLI_0) ? i_wdata_0 : i_wdata_1;
    end
  end

  // Completion: ack the owner for one cycle and capture RAM output on reads only.
  always_comb begin
    done_0    = issue_vld_q && (owner_q == CLI_0);
    done_1    = issue_vld_q && (owner_q == CLI_1);
    ack_0_d   = done_0;
    ack_1_d   = done_1;
    rdata_0_d = rdata_0_q;
    rdata_1_d = rdata_1_q;
    if (done_0 && (op_q == OP_RD)) begin
      rdata_0_d = bram_rdata;
    end
    if (done_1 && (op_q == OP_RD)) begin
      rdata_1_d = bram_rdata;
    end
  end

  // Issue and completion registers; async reset drops any in-flight op so no write lands.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      issue_vld_q <= 1'b0;
      owner_q     <= CLI_0;
      op_q        <= OP_RD;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ack_0_q     <= 1'b0;
      ack_1_q     <= 1'b0;
      rdata_0_q   <= '0;
      rdata_1_q   <= '0;
    end else begin
      issue_vld_q <= issue_vld_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ack_0_q     <= ack_0_d;
      ack_1_q     <= ack_1_d;
      rdata_0_q   <= rdata_0_d;
      rdata_1_q   <= rdata_1_d;
    end
  end

  bram #(
    .DATA_SZ (DATA_SZ),
    .ADDR_SZ (ADDR_SZ)
  ) u_bram (
    .i_clk   (i_clk),
    .i_wr_en (wr_en_q),
    .i_waddr (addr_q),
    .i_wdata (wdata_q),
    .i_rd_en (rd_en_q),
    .i_raddr (addr_q),
    .o_rdata (bram_rdata)
  );

  assign o_ack_0   = ack_0_q;
  assign o_ack_1   = ack_1_q;
  assign o_rdata_0 = rdata_0_q;
  assign o_rdata_1 = rdata_1_q;

endmodule

// File: tb/tb_bram_arb.sv
// tb/tb_bram_arb.sv - directed self-checking bench for bram_arb
module tb_bram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, wr0, wr1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;

  int errors = 0;
  int checks = 0;

`ifdef BRAM_ARB_FIXED_PRI_EN
  localparam int TIE_FIRST = 0;
`else
  localparam int TIE_FIRST = 1;
`endif
  localparam int TIE_OTHER = 1 - TIE_FIRST;

  always #5 clk = ~clk;

  bram_arb #(.DATA_SZ(16), .ADDR_SZ(8)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req_0   (req0),
    .i_wr_0    (wr0),
    .i_addr_0  (addr0),
    .i_wdata_0 (wdata0),
    .o_ack_0   (ack0),
    .o_rdata_0 (rdata0),
    .i_req_1   (req1),
    .i_wr_1    (wr1),
    .i_addr_1  (addr1),
    .i_wdata_1 (wdata1),
    .o_ack_1   (ack1),
    .o_rdata_1 (rdata1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ack_of(input int c);
    return (c == 0) ? ack0 : ack1;
  endfunction

  function automatic logic [15:0] rdata_of(input int c);
    return (c == 0) ? rdata0 : rdata1;
  endfunction

  task automatic drive(input int c, input logic req, input logic wr, input logic [7:0] a, input logic [15:0] d);
    if (c == 0) begin
      req0 = req; wr0 = wr; addr0 = a; wdata0 = d;
    end else begin
      req1 = req; wr1 = wr; addr1 = a; wdata1 = d;
    end
  endtask

  // One isolated op: grant edge, ack edge (req dropped in ack cycle), ack-clear edge.
  task automatic single_op(input string tag, input int c, input logic wr, input logic [7:0] a,
                           input logic [15:0] d, input logic [15:0] exp_rd);
    drive(c, 1'b1, wr, a, d);
    tick();
    chk({tag, "_noack_at_grant"}, 32'(ack_of(c)), 32'd0);
    tick();
    chk({tag, "_ack"}, 32'(ack_of(c)), 32'd1);
    if (!wr) chk({tag, "_rdata"}, 32'(rdata_of(c)), 32'(exp_rd));
    drive(c, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick();
    chk({tag, "_ack_clear"}, 32'(ack_of(c)), 32'd0);
  endtask

  initial begin
    logic [8:0] pat_first;
    logic [8:0] pat_other;
    pat_first = 9'h092;
    pat_other = 9'h124;

    rst = 1'b1;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    tick();
    tick();
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_rdata0", 32'(rdata0), 32'd0);
    chk("rst_rdata1", 32'(rdata1), 32'd0);
    rst = 1'b0;
    tick();

    // Single client write then read back
    single_op("wr10", 0, 1'b1, 8'h10, 16'h00A5, 16'h0000);
    single_op("rd10", 0, 1'b0, 8'h10, 16'h0000, 16'h00A5);
    chk("rd10_hold", 32'(rdata0), 32'h00A5);

    // Reset between grant and commit: write must not land, outputs cleared
    single_op("wr30", 0, 1'b1, 8'h30, 16'h1111, 16'h0000);
    drive(0, 1'b1, 1'b1, 8'h30, 16'hBEEF);
    tick();
    rst = 1'b1;
    #2;
    chk("midrst_ack0", 32'(ack0), 32'd0);
    chk("midrst_ack1", 32'(ack1), 32'd0);
    chk("midrst_rdata0", 32'(rdata0), 32'd0);
    chk("midrst_rdata1", 32'(rdata1), 32'd0);
    drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick();
    chk("midrst_noack", 32'(ack0), 32'd0);
    rst = 1'b0;
    tick();
    single_op("rd30", 0, 1'b0, 8'h30, 16'h0000, 16'h1111);

    // Contention: both hold read requests; last grant was client 0
    drive(0, 1'b1, 1'b0, 8'h10, 16'h0000);
    drive(1, 1'b1, 1'b0, 8'h30, 16'h0000);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("cont_ackf_%0d", i), 32'(ack_of(TIE_FIRST)), 32'(pat_first[i]));
      chk($sformatf("cont_acko_%0d", i), 32'(ack_of(TIE_OTHER)), 32'(pat_other[i]));
    end
    chk("cont_rdata0", 32'(rdata0), 32'h00A5);
    chk("cont_rdata1", 32'(rdata1), 32'h1111);
    drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick();

    // Tie right after a client-0 grant
    single_op("wr40", 0, 1'b1, 8'h40, 16'h5555, 16'h0000);
    drive(0, 1'b1, 1'b0, 8'h10, 16'h0000);
    drive(1, 1'b1, 1'b0, 8'h40, 16'h0000);
    tick();
    chk("tie_noack0", 32'(ack0), 32'd0);
    chk("tie_noack1", 32'(ack1), 32'd0);
    tick();
    chk("tie_first_ack", 32'(ack_of(TIE_FIRST)), 32'd1);
    chk("tie_other_noack", 32'(ack_of(TIE_OTHER)), 32'd0);
    drive(TIE_FIRST, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick();
    chk("tie_other_ack", 32'(ack_of(TIE_OTHER)), 32'd1);
    chk("tie_first_clear", 32'(ack_of(TIE_FIRST)), 32'd0);
    drive(TIE_OTHER, 1'b0, 1'b0, 8'h00, 16'h0000);
    chk("tie_rdata0", 32'(rdata0), 32'h00A5);
    chk("tie_rdata1", 32'(rdata1), 32'h5555);
    tick();

    // Write by client 0 then same-address read by client 1 in the next slot
    drive(0, 1'b1, 1'b1, 8'h20, 16'h1234);
    tick();
    drive(1, 1'b1, 1'b0, 8'h20, 16'h0000);
    tick();
    chk("fwd_ack0", 32'(ack0), 32'd1);
    chk("fwd_noack1", 32'(ack1), 32'd0);
    drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick();
    chk("fwd_ack1", 32'(ack1), 32'd1);
    chk("fwd_clear0", 32'(ack0), 32'd0);
    chk("fwd_rdata1", 32'(rdata1), 32'h1234);
    drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);

    // Client 1 idle while client 0 writes elsewhere: its read data must hold
    for (int k = 0; k < 3; k++) begin
      single_op($sformatf("hold_wr%0d", k), 0, 1'b1, 8'(8'h50 + k), 16'(16'h7770 + k), 16'h0000);
      chk($sformatf("hold_rdata1_%0d", k), 32'(rdata1), 32'h1234);
    end
    tick();
    chk("hold_rdata1_end", 32'(rdata1), 32'h1234);
    chk("hold_rdata0_end", 32'(rdata0), 32'h00A5);
    single_op("rd51", 0, 1'b0, 8'h51, 16'h0000, 16'h7771);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
